nanov_spi_mem_ctrl: RTL and testbench

// Parametrised SPI/dual/quad memory controller for the nanoV family. It replaces the ad-hoc
// SPI sequencing embedded in the core with a request/response engine that issues command,

---
 rtl/nanov_spi_mem_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_nanov_spi_mem_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nanov_spi_mem_ctrl.sv
// nanov_spi_mem_ctrl: request/response SPI, dual or quad memory controller.
// Sequences command, address, dummy and data phases. Keeps CS low after a read
// so that a read of the following address streams on without a new header.
module nanov_spi_mem_ctrl #(
    parameter int          LANES        = 1,
    parameter int          ADDR_BITS    = 24,
    parameter int          DUMMY_CYCLES = 0,
    parameter logic [7:0]  READ_CMD     = 8'h03,
    parameter logic [7:0]  WRITE_CMD    = 8'h02
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [1:0]           req_size,
    input  logic [31:0]          req_wdata,
    input  logic                 abort,
    output logic [31:0]          rdata,
    output logic                 rdata_valid,
    output logic                 spi_select,
    output logic                 spi_clk_enable,
    output logic [LANES-1:0]     spi_out,
    output logic [LANES-1:0]     spi_oe,
    input  logic [LANES-1:0]     spi_in
);

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("LANES must be 1, 2 or 4");
    end
    if (ADDR_BITS % LANES != 0) begin : g_bad_addr_bits
        $error("ADDR_BITS must be a multiple of LANES");
    end

    localparam int ADDR_CYC = ADDR_BITS / LANES;

    typedef enum logic [2:0] {IDLE, DESEL, CMD, ADDR, DUMMY, DATA, STREAM} state_t;

    state_t                 state, state_d;
    logic [7:0]             cnt, cnt_d;
    logic [7:0]             cmd_sh;
    logic [ADDR_BITS-1:0]   addr_sh;
    logic [31:0]            data_sh;
    logic [31-LANES:0]      rx;
    logic [31:0]            rx_next;
    logic                   wr_q;
    logic [1:0]             size_q;
    logic [ADDR_BITS-1:0]   next_addr;
    logic                   accept;
    logic                   hit;

    // Number of DATA cycles minus one for a given request size
    function automatic logic [7:0] data_cyc(input logic [1:0] sz);
        int b;
        b = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
        return 8'(b / LANES - 1);
    endfunction

    // Size in bytes, widened to the address width for next_addr arithmetic
    function automatic logic [ADDR_BITS-1:0] size_inc(input logic [1:0] sz);
        logic [ADDR_BITS-1:0] r;
        r = '0;
        r[2:0] = (sz == 2'd0) ? 3'd1 : (sz == 2'd1) ? 3'd2 : 3'd4;
        return r;
    endfunction

    // Bytes arrive first-byte-most-significant; reorder to little-endian, zero-extend
    function automatic logic [31:0] assemble(input logic [31:0] r, input logic [1:0] sz);
        case (sz)
            2'd0:    return {24'h0, r[7:0]};
            2'd1:    return {16'h0, r[7:0], r[15:8]};
            default: return {r[7:0], r[15:8], r[23:16], r[31:24]};
        endcase
    endfunction

    assign rx_next = {rx, spi_in};

    // Next-state, handshake and pin drive decode from the current state
    always_comb begin
        state_d        = state;
        cnt_d          = (cnt != 8'd0) ? cnt - 8'd1 : cnt;
        req_ready      = (state == IDLE || state == STREAM) && !abort;
        accept         = req_valid && req_ready;
        hit            = (state == STREAM) && !req_write && (req_addr == next_addr);
        spi_select     = 1'b1;
        spi_clk_enable = 1'b0;
        spi_out        = '0;
        spi_oe         = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = CMD;
                    cnt_d   = 8'd7;
                end
            end
            STREAM: begin
                spi_select = 1'b0;
                if (accept) begin
                    if (hit) begin
                        state_d = DATA;
                        cnt_d   = data_cyc(req_size);
                    end else begin
                        state_d = DESEL;
                    end
                end
            end
            DESEL: begin
                state_d = CMD;
                cnt_d   = 8'd7;
            end
            CMD: begin
                spi_select     = 1'b0;
                spi_clk_enable = 1'b1;
                spi_out[0]     = cmd_sh[7];
                spi_oe[0]      = 1'b1;
                if (cnt == 8'd0) begin
                    state_d = ADDR;
                    cnt_d   = 8'(ADDR_CYC - 1);
                end
            end
            ADDR: begin
                spi_select     = 1'b0;
                spi_clk_enable = 1'b1;
                spi_out        = addr_sh[ADDR_BITS-1 -: LANES];
                spi_oe         = '1;
                if (cnt == 8'd0) begin
                    if (!wr_q && DUMMY_CYCLES > 0) begin
                        state_d = DUMMY;
                        cnt_d   = 8'(DUMMY_CYCLES - 1);
                    end else begin
                        state_d = DATA;
                        cnt_d   = data_cyc(size_q);
                    end
                end
            end
            DUMMY: begin
                spi_select     = 1'b0;
                spi_clk_enable = 1'b1;
                if (cnt == 8'd0) begin
                    state_d = DATA;
                    cnt_d   = data_cyc(size_q);
                end
            end
            DATA: begin
                spi_select     = 1'b0;
                spi_clk_enable = 1'b1;
                if (wr_q) begin
                    spi_out = data_sh[31 -: LANES];
                    spi_oe  = '1;
                end
                if (cnt == 8'd0) state_d = wr_q ? IDLE : STREAM;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // State register plus shift registers for header, write data and read data
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            cmd_sh      <= '0;
            addr_sh     <= '0;
            data_sh     <= '0;
            rx          <= '0;
            wr_q        <= 1'b0;
            size_q      <= '0;
            next_addr   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            rdata_valid <= 1'b0;
            if (accept) begin
                wr_q      <= req_write;
                size_q    <= req_size;
                cmd_sh    <= req_write ? WRITE_CMD : READ_CMD;
                addr_sh   <= req_addr;
                data_sh   <= {req_wdata[7:0], req_wdata[15:8], req_wdata[23:16], req_wdata[31:24]};
                next_addr <= req_addr + size_inc(req_size);
            end else begin
                case (state)
                    CMD:  cmd_sh  <= cmd_sh << 1;
                    ADDR: addr_sh <= addr_sh << LANES;
                    DATA: begin
                        data_sh <= data_sh << LANES;
                        rx      <= rx_next[31-LANES:0];
                        if (cnt == 8'd0 && !wr_q && !abort) begin
                            rdata       <= assemble(rx_next, size_q);
                            rdata_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nanov_spi_mem_ctrl.sv
// Bench for nanov_spi_mem_ctrl: a single-lane and a quad-lane instance, each
// attached to a behavioural SPI memory model, checked through a read scoreboard.
module tb_nanov_spi_mem_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req_valid, req_write, abort;
    logic [23:0] req_addr  [2];
    logic [1:0]  req_size  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  si        [2];

    wire  [1:0]  req_ready, rdata_valid, spi_select, spi_clk_enable;
    wire  [31:0] rdata [2];
    wire         so1, oe1;
    wire  [3:0]  so4, oe4;
    wire  [3:0]  so [2];
    wire  [3:0]  oe [2];
    assign so[0] = {3'b000, so1};
    assign oe[0] = {3'b000, oe1};
    assign so[1] = so4;
    assign oe[1] = oe4;

    nanov_spi_mem_ctrl u1 (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_size(req_size[0]), .req_wdata(req_wdata[0]),
        .abort(abort[0]), .rdata(rdata[0]), .rdata_valid(rdata_valid[0]),
        .spi_select(spi_select[0]), .spi_clk_enable(spi_clk_enable[0]),
        .spi_out(so1), .spi_oe(oe1), .spi_in(si[0][0])
    );

    nanov_spi_mem_ctrl #(.LANES(4), .DUMMY_CYCLES(6), .READ_CMD(8'hEB)) u4 (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_size(req_size[1]), .req_wdata(req_wdata[1]),
        .abort(abort[1]), .rdata(rdata[1]), .rdata_valid(rdata_valid[1]),
        .spi_select(spi_select[1]), .spi_clk_enable(spi_clk_enable[1]),
        .spi_out(so4), .spi_oe(oe4), .spi_in(si[1])
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          acc;
    } sb_t;
    sb_t sbq0[$];
    sb_t sbq1[$];

    logic [7:0]  mem [int unsigned];
    logic [7:0]  exp_cmd  [2];
    logic [23:0] exp_addr [2];
    int          hdrs     [2] = '{0, 0};
    int          dn       [2] = '{0, 0};
    logic [7:0]  dcmd     [2];
    logic [23:0] daddr    [2];
    logic [7:0]  dwb      [2];
    int          hirun    [2] = '{0, 0};
    int          lastrun  [2] = '{0, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        if (mem.exists(32'(a))) return mem[32'(a)];
        return a[7:0] ^ a[15:8] ^ 8'h5C;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [23:0] a, input logic [1:0] s);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem_rd(a);
        b1 = mem_rd(24'(a + 24'd1));
        b2 = mem_rd(24'(a + 24'd2));
        b3 = mem_rd(24'(a + 24'd3));
        case (s)
            2'd0:    return {24'h0, b0};
            2'd1:    return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    function automatic int sb_size(input int i);
        return (i == 0) ? sbq0.size() : sbq1.size();
    endfunction

    // SPI memory model: captures header on SCK cycles, serves/stores data MSB first
    always @(negedge clk) begin
        int L, AC, DC, idx, g;
        logic [7:0]  b, rc;
        logic [3:0]  m;
        logic [23:0] ba;
        for (int i = 0; i < 2; i++) begin
            L  = (i == 0) ? 1 : 4;
            AC = 24 / L;
            m  = (i == 0) ? 4'b0001 : 4'b1111;
            rc = (i == 0) ? 8'h03 : 8'hEB;
            DC = (i == 1 && dcmd[i] == rc) ? 6 : 0;
            if (spi_select[i] === 1'b1) begin
                dn[i] = 0;
            end else if (spi_clk_enable[i] === 1'b1) begin
                if (dn[i] < 8) begin
                    dcmd[i] = {dcmd[i][6:0], so[i][0]};
                    check("cmd_oe", 32'(oe[i]), 32'h1);
                end else if (dn[i] < 8 + AC) begin
                    daddr[i] = 24'((daddr[i] << L) | 24'(so[i] & m));
                    check("addr_oe", 32'(oe[i]), 32'(m));
                    if (dn[i] == 8 + AC - 1) begin
                        hdrs[i]++;
                        check("cmd_byte", 32'(dcmd[i]), 32'(exp_cmd[i]));
                        check("addr_bits", 32'(daddr[i]), 32'(exp_addr[i]));
                    end
                end else if (dn[i] < 8 + AC + DC) begin
                    check("dummy_oe", 32'(oe[i]), 32'h0);
                end else begin
                    idx = dn[i] - 8 - AC - DC;
                    g   = idx % (8 / L);
                    ba  = 24'(daddr[i] + 24'(idx / (8 / L)));
                    if (dcmd[i] == rc) begin
                        b     = mem_rd(ba);
                        si[i] = 4'(b >> (8 - L * (g + 1))) & m;
                        check("read_oe", 32'(oe[i]), 32'h0);
                    end else begin
                        dwb[i] = 8'((dwb[i] << L) | 8'(so[i] & m));
                        check("write_oe", 32'(oe[i]), 32'(m));
                        if (g == 8 / L - 1) mem[32'(ba)] = dwb[i];
                    end
                end
                dn[i]++;
            end
        end
    end

    // Scoreboard pop on rdata_valid, and CS-high run-length tracking
    always @(posedge clk) begin
        sb_t e;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (spi_select[i] === 1'b1) hirun[i]++;
            else begin
                if (hirun[i] != 0) lastrun[i] = hirun[i];
                hirun[i] = 0;
            end
            if (rstn === 1'b1 && rdata_valid[i] === 1'b1) begin
                if (sb_size(i) == 0) begin
                    check("spurious_rdata_valid", 32'(rdata_valid[i]), 32'h0);
                end else begin
                    e = (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
                    check("rdata", rdata[i], e.data);
                    check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                end
            end
        end
    end

    task automatic accept(input int i, input logic w, input logic [23:0] a, input logic [1:0] s,
                          input logic [31:0] wd, output int acc);
        bit ok;
        req_write[i] = w;
        req_addr[i]  = a;
        req_size[i]  = s;
        req_wdata[i] = wd;
        exp_addr[i]  = a;
        exp_cmd[i]   = w ? 8'h02 : ((i == 0) ? 8'h03 : 8'hEB);
        req_valid[i] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (req_ready[i] === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        check("accept", 32'(ok), 32'h1);
        req_valid[i] = 1'b0;
        acc = cyc;
    endtask

    task automatic read_chk(input int i, input logic [23:0] a, input logic [1:0] s,
                            input int lat, input int hdr);
        sb_t e;
        int  h0, acc;
        h0     = hdrs[i];
        e.data = exp_rd(a, s);
        e.lat  = lat;
        accept(i, 1'b0, a, s, 32'h0, acc);
        e.acc = acc;
        if (i == 0) sbq0.push_back(e); else sbq1.push_back(e);
        for (int k = 0; k < 300 && sb_size(i) != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("read_done", 32'(sb_size(i)), 32'h0);
        check("header_count", 32'(hdrs[i] - h0), 32'(hdr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, n;
        rstn      = 1'b0;
        req_valid = '0;
        req_write = '0;
        abort     = '0;
        for (int i = 0; i < 2; i++) begin
            req_addr[i]  = '0;
            req_size[i]  = '0;
            req_wdata[i] = '0;
            si[i]        = '0;
        end
        mem[32'h100] = 8'h13;
        mem[32'h101] = 8'h37;
        mem[32'h102] = 8'hBE;
        mem[32'h103] = 8'hEF;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_select", 32'(spi_select[i]), 32'h1);
            check("rst_clk_en", 32'(spi_clk_enable[i]), 32'h0);
            check("rst_out", 32'(so[i]), 32'h0);
            check("rst_oe", 32'(oe[i]), 32'h0);
            check("rst_rdata", rdata[i], 32'h0);
            check("rst_valid", 32'(rdata_valid[i]), 32'h0);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single lane: cold read, stream hit, stream miss with DESEL
        read_chk(0, 24'h000100, 2'd2, 65, 1);
        check("first_rdata_value", rdata[0], 32'hEFBE3713);
        read_chk(0, 24'h000104, 2'd2, 33, 0);
        check("stream_cs_low", 32'(spi_select[0]), 32'h0);
        read_chk(0, 24'h000200, 2'd2, 66, 1);
        check("desel_cs_high_cycles", 32'(lastrun[0]), 32'h1);

        // Write one byte, CS must drop after CMD+ADDR+8 data cycles
        accept(0, 1'b1, 24'h000010, 2'd0, 32'h000000A5, acc);
        for (int k = 0; k < 100 && spi_select[0] === 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        n = 0;
        for (int k = 0; k < 100 && spi_select[0] === 1'b0; k++) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("write_cs_low_cycles", 32'(n), 32'd40);
        check("write_byte_stored", 32'(mem_rd(24'h000010)), 32'hA5);
        read_chk(0, 24'h000010, 2'd1, 49, 1);

        // Abort mid-ADDR together with a new request
        accept(0, 1'b0, 24'h000300, 2'd2, 32'h0, acc);
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check("abort_pre_clk_en", 32'(spi_clk_enable[0]), 32'h1);
        req_addr[0]  = 24'h000304;
        req_valid[0] = 1'b1;
        abort[0]     = 1'b1;
        check("ready_during_abort", 32'(req_ready[0]), 32'h0);
        @(posedge clk);
        #1;
        abort[0]     = 1'b0;
        req_valid[0] = 1'b0;
        check("abort_select", 32'(spi_select[0]), 32'h1);
        check("abort_clk_en", 32'(spi_clk_enable[0]), 32'h0);
        check("abort_oe", 32'(oe[0]), 32'h0);
        repeat (80) begin
            @(posedge clk);
            #1;
        end
        check("abort_rdata_held", rdata[0], exp_rd(24'h000010, 2'd1));
        read_chk(0, 24'h000304, 2'd2, 65, 1);

        // Reset during DATA
        accept(0, 1'b0, 24'h000400, 2'd2, 32'h0, acc);
        repeat (38) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_clk_en", 32'(spi_clk_enable[0]), 32'h1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_select", 32'(spi_select[0]), 32'h1);
        check("mid_rst_clk_en", 32'(spi_clk_enable[0]), 32'h0);
        check("mid_rst_out", 32'(so[0]), 32'h0);
        check("mid_rst_oe", 32'(oe[0]), 32'h0);
        check("mid_rst_rdata", rdata[0], 32'h0);
        check("mid_rst_valid", 32'(rdata_valid[0]), 32'h0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Address wrap: top of memory then 0 streams
        read_chk(0, 24'hFFFFFE, 2'd1, 49, 1);
        read_chk(0, 24'h000000, 2'd1, 17, 0);

        // Quad lane with 6 dummy cycles
        read_chk(1, 24'h000100, 2'd2, 29, 1);
        check("quad_rdata_value", rdata[1], 32'hEFBE3713);
        read_chk(1, 24'h000104, 2'd2, 9, 0);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
